// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared types and helpers for the sequential shift unit and its barrel
// shifter sub-module.
//   shift_op_t : shift mode encoding (00 LSL, 01 LSR, 10 ASR, 11 ROR)
//   state_t    : control FSM states of shift_unit_seq
//   eff_count  : number of one-bit steps a request really needs
// ---------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Linear shifts saturate at n steps because after n steps every bit has
  // been replaced by fill.  A rotation by n is the identity, so rotations
  // only need the amount modulo n.  Operands are handled as 32-bit values,
  // which covers any width up to 32 bits.
  function automatic logic [31:0] eff_count(input logic [31:0] amount,
                                            input shift_op_t op,
                                            input int unsigned n);
    if (op == OP_ROR) begin
      return amount % n;
    end
    return (amount >= n) ? n : amount;
  endfunction

endpackage

// File: rtl/shift_unit_seq_barrel.sv
// ---------------------------------------------------------------------------
// barrel_shift
// Single-step combinational shifter producing the same result and carry
// that shift_unit_seq produces after all of its one-bit steps.
// Ports:
//   a       in  N  operand
//   amount  in  N  raw shift amount (unsigned, reduced internally)
//   op      in  2  shift mode (shift_op_t)
//   result  out N  shifted value
//   carry   out 1  last bit shifted out / last bit rotated, 0 for no shift
// ---------------------------------------------------------------------------
module barrel_shift
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] amount,
  input  shift_op_t    op,
  output logic [N-1:0] result,
  output logic         carry
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0]  k;
  logic [2*N-1:0] ext;

  assign k = CW'(eff_count(32'(amount), op, N));

  // Each mode works on a double-width vector so the bits pushed out of the
  // operand land in the other half; the last bit removed always ends up
  // right next to the result field, which is where carry is taken from.
  always_comb begin
    ext    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_LSL: begin
        ext    = {{N{1'b0}}, a} << k;
        result = ext[N-1:0];
        carry  = (k != '0) & ext[N];
      end
      OP_LSR: begin
        ext    = {a, {N{1'b0}}} >> k;
        result = ext[2*N-1:N];
        carry  = (k != '0) & ext[N-1];
      end
      OP_ASR: begin
        ext    = $signed({a, {N{1'b0}}}) >>> k;
        result = ext[2*N-1:N];
        carry  = (k != '0) & ext[N-1];
      end
      default: begin
        ext    = {a, a} >> k;
        result = ext[N-1:0];
        carry  = (k != '0) & ext[N-1];
      end
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// ---------------------------------------------------------------------------
// shift_unit_seq
// Multi-cycle shifter (LSL, LSR, ASR, ROR) with valid/ready handshakes and
// sign/zero/carry flags.  By default it shifts one bit per cycle; when the
// macro SHIFT_UNIT_FAST_EN is defined the result comes from barrel_shift in
// a single step and the SHIFT state is never entered.
// Ports:
//   clk        in  1  clock, rising edge
//   rst        in  1  asynchronous active-low reset
//   in_valid   in  1  request valid
//   in_ready   out 1  idle, request can be accepted
//   op         in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
//   a          in  N  operand
//   aDesplace  in  N  unsigned shift amount
//   out_valid  out 1  result valid
//   out_ready  in  1  consumer takes the result
//   result     out N  shifted value
//   sign       out 1  result MSB
//   zero       out 1  result is all zeros
//   carry      out 1  last bit shifted out / rotated
//   busy       out 1  iterative shift in progress
// ---------------------------------------------------------------------------
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] aDesplace,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         sign,
  output logic         zero,
  output logic         carry,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);

  state_t       state_q, state_d;
  logic [N-1:0] res_q, res_d;
  logic         carry_q, carry_d;
  logic         sign_q, sign_d;
  logic         zero_q, zero_d;
  shift_op_t    opIn;

  assign opIn = shift_op_t'(op);

`ifdef SHIFT_UNIT_FAST_EN
  logic [N-1:0] bsResult;
  logic         bsCarry;

  barrel_shift #(.N(N)) u_barrel (
    .a      (a),
    .amount (aDesplace),
    .op     (opIn),
    .result (bsResult),
    .carry  (bsCarry)
  );
`else
  logic [N-1:0]  work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  shift_op_t     op_q, op_d;
  logic [CW-1:0] effCnt;
  logic [N-1:0]  stepVal;
  logic          stepCarry;

  assign effCnt = CW'(eff_count(32'(aDesplace), opIn, N));

  // One-bit step of the working register.  ASR replicates the current MSB,
  // which is still the original MSB because every ASR step preserves it.
  always_comb begin
    stepVal   = work_q;
    stepCarry = work_q[0];
    case (op_q)
      OP_LSL: begin
        stepVal   = {work_q[N-2:0], 1'b0};
        stepCarry = work_q[N-1];
      end
      OP_LSR:  stepVal = {1'b0, work_q[N-1:1]};
      OP_ASR:  stepVal = {work_q[N-1], work_q[N-1:1]};
      default: stepVal = {work_q[0], work_q[N-1:1]};
    endcase
  end
`endif

  // State and datapath registers.  Reset discards any request in flight so
  // no result can be presented after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
`ifdef SHIFT_UNIT_FAST_EN
`else
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_LSL;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
`ifdef SHIFT_UNIT_FAST_EN
`else
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
`endif
    end
  end

  // Next-state logic.  The visible result and flags are only loaded when
  // the FSM moves into DONE, so they stay frozen while the consumer stalls
  // and keep their last value outside DONE.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    carry_d = carry_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
`ifdef SHIFT_UNIT_FAST_EN
`else
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef SHIFT_UNIT_FAST_EN
          res_d   = bsResult;
          carry_d = bsCarry;
          sign_d  = bsResult[N-1];
          zero_d  = (bsResult == '0);
          state_d = DONE;
`else
          work_d  = a;
          op_d    = opIn;
          cnt_d   = effCnt;
          carry_d = 1'b0;
          if (effCnt == '0) begin
            res_d   = a;
            sign_d  = a[N-1];
            zero_d  = (a == '0);
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
`endif
        end
      end
      SHIFT: begin
`ifdef SHIFT_UNIT_FAST_EN
        state_d = DONE;
`else
        work_d = stepVal;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = stepVal;
          carry_d = stepCarry;
          sign_d  = stepVal[N-1];
          zero_d  = (stepVal == '0);
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign carry     = carry_q;
  assign sign      = sign_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_unit_seq
// Self-checking bench for shift_unit_seq (N = 8).  Expected values come from
// an arithmetic reference model (multiply/divide by powers of two).  The
// barrel_shift sub-module is also exercised directly against that model.
// ---------------------------------------------------------------------------
module tb_shift_unit_seq;
  import shift_pkg::*;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] aDesplace;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         sign;
  logic         zero;
  logic         carry;
  logic         busy;

  logic [N-1:0] bA;
  logic [N-1:0] bAmt;
  shift_op_t    bOp;
  logic [N-1:0] bResult;
  logic         bCarry;

  int total = 0;
  int bad   = 0;

  shift_unit_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .aDesplace (aDesplace),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sign      (sign),
    .zero      (zero),
    .carry     (carry),
    .busy      (busy)
  );

  barrel_shift #(.N(N)) refBarrel (
    .a      (bA),
    .amount (bAmt),
    .op     (bOp),
    .result (bResult),
    .carry  (bCarry)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: shifts expressed as multiplication/division by powers
  // of two on plain integers, with saturation and modulo rules applied to
  // the amount first.
  function automatic void refModel(input logic [7:0] ma, input logic [1:0] mop,
                                   input logic [7:0] mamt, output logic [7:0] r,
                                   output logic c, output int lat);
    int k, v, s, wide;
    v = int'(ma);
    if (mop == 2'b11) k = int'(mamt) % 8;
    else k = (int'(mamt) > 8) ? 8 : int'(mamt);
    s = (v >= 128) ? v - 256 : v;
    c = 1'b0;
    case (mop)
      2'b00: begin
        wide = v * (1 << k);
        r = 8'(wide % 256);
        if (k != 0) c = 1'(wide / 256);
      end
      2'b01: begin
        r = 8'(v / (1 << k));
        if (k != 0) c = 1'(v / (1 << (k - 1)));
      end
      2'b10: begin
        r = 8'(s >>> k);
        if (k != 0) c = 1'(s >>> (k - 1));
      end
      default: begin
        r = 8'(v / (1 << k) + (v * (1 << (8 - k))) % 256);
        if (k != 0) c = 1'(v / (1 << (k - 1)));
      end
    endcase
`ifdef SHIFT_UNIT_FAST_EN
    lat = 1;
`else
    lat = (k == 0) ? 1 : k + 1;
`endif
  endfunction

  // Present one request, hold it for the accept edge, then scramble the
  // inputs and count edges until out_valid shows up (bounded).
  task automatic applyStimulus(input logic [7:0] ta, input logic [1:0] top,
                               input logic [7:0] tamt, output int lat);
    @(negedge clk);
    a = ta; op = top; aDesplace = tamt; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom); op = 2'($urandom); aDesplace = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Let the consumer take the result; FSM returns to IDLE.
  task automatic releaseResult();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; a = '0; aDesplace = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({result, sign, zero, carry, out_valid, busy} !== 13'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b exp=0", {result, sign, zero, carry, out_valid, busy});
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Directed vectors from the plan (cases 1-4) plus a few extra boundaries.
  task automatic test_directed();
    logic [7:0] va [8] = '{8'b10110100, 8'b10010000, 8'b10010000, 8'b00000001,
                           8'hC0, 8'h5A, 8'h81, 8'h81};
    logic [1:0] vo [8] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01, 2'b11};
    logic [7:0] vm [8] = '{8'd3, 8'd2, 8'd20, 8'd9, 8'd12, 8'd0, 8'd8, 8'd8};
    logic [7:0] er;
    logic ec;
    int el, lat;
    for (int i = 0; i < 8; i++) begin
      refModel(va[i], vo[i], vm[i], er, ec, el);
      applyStimulus(va[i], vo[i], vm[i], lat);
      total++;
      if (out_valid !== 1'b1 || lat !== el) begin
        bad++;
        $display("[TB] FAIL dir_latency case=%0d got=%0d valid=%b exp=%0d", i, lat, out_valid, el);
      end
      total++;
      if (result !== er || carry !== ec) begin
        bad++;
        $display("[TB] FAIL dir_result case=%0d got=%h/%b exp=%h/%b", i, result, carry, er, ec);
      end
      total++;
      if (sign !== er[7] || zero !== (er == 8'h00) || in_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL dir_flags case=%0d got s=%b z=%b rdy=%b exp s=%b z=%b rdy=0",
                 i, sign, zero, in_ready, er[7], er == 8'h00);
      end
      releaseResult();
    end
  endtask

  task automatic test_random();
    logic [7:0] ta, tamt, er;
    logic [1:0] top;
    logic ec;
    int el, lat;
    for (int i = 0; i < 40; i++) begin
      ta = 8'($urandom);
      top = 2'($urandom);
      tamt = (i % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 17));
      refModel(ta, top, tamt, er, ec, el);
      applyStimulus(ta, top, tamt, lat);
      total++;
      if (out_valid !== 1'b1 || lat !== el || result !== er || carry !== ec ||
          sign !== er[7] || zero !== (er == 8'h00)) begin
        bad++;
        $display("[TB] FAIL rand a=%h op=%0d amt=%0d got r=%h c=%b s=%b z=%b lat=%0d exp r=%h c=%b lat=%0d",
                 ta, top, tamt, result, carry, sign, zero, lat, er, ec, el);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      releaseResult();
    end
  endtask

  // Stall in DONE with a second request pending; it must be taken only
  // after the first result is consumed.
  task automatic test_back_to_back();
    logic [7:0] er1, er2, hold;
    logic ec1, ec2;
    int el1, el2, lat;
    refModel(8'b10110100, 2'b01, 8'd3, er1, ec1, el1);
    refModel(8'h3C, 2'b00, 8'd2, er2, ec2, el2);
    applyStimulus(8'b10110100, 2'b01, 8'd3, lat);
    hold = result;
    @(negedge clk);
    a = 8'h3C; op = 2'b00; aDesplace = 8'd2; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er1 ||
          carry !== ec1 || sign !== er1[7] || zero !== (er1 == 8'h00) || result !== hold) begin
        bad++;
        $display("[TB] FAIL stall_hold cyc=%0d got v=%b rdy=%b r=%h c=%b exp v=1 rdy=0 r=%h c=%b",
                 i, out_valid, in_ready, result, carry, er1, ec1);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (out_valid !== 1'b1 || lat !== el2 || result !== er2 || carry !== ec2) begin
      bad++;
      $display("[TB] FAIL queued_req got v=%b lat=%0d r=%h c=%b exp lat=%0d r=%h c=%b",
               out_valid, lat, result, carry, el2, er2, ec2);
    end
    releaseResult();
  endtask

  // Reset asserted between edges while case 1 is in flight.
  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    a = 8'b10110100; op = 2'b01; aDesplace = 8'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
`ifdef SHIFT_UNIT_FAST_EN
    if (busy !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_state got busy=%b v=%b exp busy=0 v=1", busy, out_valid);
    end
`else
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_state got busy=%b v=%b exp busy=1 v=0", busy, out_valid);
    end
`endif
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({result, sign, zero, carry, out_valid, busy} !== 13'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL async_reset got=%b rdy=%b exp=0 rdy=1",
               {result, sign, zero, carry, out_valid, busy}, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("[TB] FAIL post_reset_idle got=%0d active cycles exp=0", seen);
    end
  endtask

  task automatic test_barrel();
    logic [7:0] er;
    logic ec;
    int el;
    for (int i = 0; i < 60; i++) begin
      bA = 8'($urandom);
      bOp = shift_op_t'(2'($urandom));
      bAmt = (i % 3 == 0) ? 8'($urandom) : 8'($urandom_range(0, 17));
      #1;
      refModel(bA, 2'(bOp), bAmt, er, ec, el);
      total++;
      if (bResult !== er || bCarry !== ec) begin
        bad++;
        $display("[TB] FAIL barrel a=%h op=%0d amt=%0d got=%h/%b exp=%h/%b",
                 bA, bOp, bAmt, bResult, bCarry, er, ec);
      end
    end
  endtask

  initial begin
    bA = '0; bAmt = '0; bOp = OP_LSL;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_barrel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
